// File: rtl/pulse_train_gen.sv
// Pulse train generator: loads a count word and emits exactly that many pulses of
// HIGH_CYC/LOW_CYC width. Define PULSE_GRAY_DECODE_EN to accept a Gray-coded count_in.
module pulse_train_gen #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned HIGH_CYC = 1,
    parameter int unsigned LOW_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             start,
    input  logic [WIDTH-1:0] count_in,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] remaining
);

    localparam int unsigned PH_MAX = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] HIGH_LAST = PH_W'(HIGH_CYC - 1);
    localparam logic [PH_W-1:0] LOW_LAST  = PH_W'(LOW_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] count_bin_c;

`ifdef PULSE_GRAY_DECODE_EN
    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        count_bin_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            count_bin_c[i] = ^(count_in >> i);
        end
    end
`else
    assign count_bin_c = count_in;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rem_d   = rem_q;
        pulse_d = pulse_q;
        busy_d  = busy_q;
        done_d  = done_q;
        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    done_d = 1'b0;
                    if (start) begin
                        phase_d = '0;
                        if (count_bin_c != '0) begin
                            state_d = ST_HIGH;
                            pulse_d = 1'b1;
                            busy_d  = 1'b1;
                            rem_d   = count_bin_c - WIDTH'(1);
                        end else begin
                            // Empty train: straight to the done strobe, busy never rises.
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            rem_d   = '0;
                        end
                    end
                end
                ST_HIGH: begin
                    if (phase_q == HIGH_LAST) begin
                        state_d = ST_LOW;
                        pulse_d = 1'b0;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
                ST_LOW: begin
                    if (phase_q == LOW_LAST) begin
                        phase_d = '0;
                        if (rem_q != '0) begin
                            state_d = ST_HIGH;
                            pulse_d = 1'b1;
                            rem_d   = rem_q - WIDTH'(1);
                        end else begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            rem_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rem_q   <= rem_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign remaining = rem_q;

endmodule
